axis_traffic_gen: RTL

Per-port AXI-Stream packet source that drives one axis_in_* port of the ring NoC top level, in the user clock domain. It emits packets with configurable length, inter-packet gap, count and destination pattern. Each beat carries a self-describing payload (source, sequence number, beat index) so a downstream checker can verify ordering and integrity. The block also exposes sent-packet and sent-beat counters for bring-up and throughput measurement.

---
 rtl/noc_tg_pkg.sv | 37 +++
 rtl/axis_traffic_gen_if.sv | 23 ++
 rtl/noc_lfsr16.sv | 33 +++
 rtl/axis_traffic_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_tg_pkg.sv
// Shared types and constants for the NoC traffic generator and any payload checker.
// The payload field offsets let checkers decode beats with the same layout.
package noc_tg_pkg;

    typedef enum logic [1:0] {
        RR    = 2'd0,
        LFSR  = 2'd1,
        FIXED = 2'd2
    } dest_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } tg_state_t;

    // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Fibonacci form
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam int unsigned BEAT_LSB  = 0;
    localparam int unsigned SEQ_LSB   = 16;
    localparam int unsigned SRC_LSB   = 32;
    localparam int unsigned LEN_LSB   = 40;
    localparam int unsigned BEAT_W    = 16;
    localparam int unsigned SEQ_W     = 16;
    localparam int unsigned SRC_W     = 8;
    localparam int unsigned LEN_W     = 8;
    localparam int unsigned PAYLOAD_W = 48;

    function automatic int unsigned first_dest(input int unsigned src, input int unsigned n,
                                               input bit skip);
        return (skip && src == 0) ? (1 % n) : 0;
    endfunction

endpackage

// File: rtl/axis_traffic_gen_if.sv
// AXI-Stream bundle driven by the traffic generator into one NoC ingress port.
interface axis_traffic_gen_if #(
    parameter int unsigned TID_WIDTH   = 2,
    parameter int unsigned TDEST_WIDTH = 4,
    parameter int unsigned TDATA_WIDTH = 512
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tlast;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;

    modport master (
        output tvalid, tdata, tlast, tid, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tlast, tid, tdest,
        output tready
    );
endinterface

// File: rtl/noc_lfsr16.sv
// 16-bit Fibonacci LFSR; next_o is the value one step ahead so callers can use it
// in the same cycle they request the step.
module noc_lfsr16
    import noc_tg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        step_i,
    input  logic        load_seed_i,
    output logic [15:0] next_o
);
    logic [15:0] lfsr_q, lfsr_d;
    logic        fb;

    always_comb begin
        fb     = ^(lfsr_q & LFSR_TAPS);
        next_o = {fb, lfsr_q[15:1]};
        lfsr_d = lfsr_q;
        if (load_seed_i) begin
            lfsr_d = LFSR_SEED;
        end else if (step_i) begin
            lfsr_d = next_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
endmodule

// File: rtl/axis_traffic_gen.sv
// Per-port AXI-Stream packet source with self-describing payload, destination
// patterns and saturating sent-packet / sent-beat counters.
module axis_traffic_gen
    import noc_tg_pkg::*;
#(
    parameter int unsigned NUM_ROUTERS = 4,
    parameter int unsigned TID_WIDTH   = 2,
    parameter int unsigned TDEST_WIDTH = 4,
    parameter int unsigned TDATA_WIDTH = 512,
    parameter int unsigned SRC_ID      = 0,
    parameter bit          SKIP_SELF   = 1'b1,
    parameter int unsigned LEN_WIDTH   = 8,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [LEN_WIDTH-1:0]   pkt_len,
    input  logic [LEN_WIDTH-1:0]   gap_cycles,
    input  logic [CNT_WIDTH-1:0]   num_packets,
    input  logic [1:0]             dest_mode,
    input  logic [TDEST_WIDTH-1:0] fixed_dest,
    input  logic [TID_WIDTH-1:0]   tid_cfg,
    axis_traffic_gen_if.master     axis,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   pkts_sent,
    output logic [CNT_WIDTH-1:0]   beats_sent
);
    localparam logic [TDEST_WIDTH-1:0] FIRST_DEST =
        TDEST_WIDTH'(first_dest(SRC_ID, NUM_ROUTERS, SKIP_SELF));

    tg_state_t              state_q, state_d;
    logic [LEN_WIDTH-1:0]   beat_q, beat_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   gap_q, gap_d;
    logic [LEN_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
    logic [CNT_WIDTH-1:0]   num_q, num_d;
    logic [SEQ_W-1:0]       seq_q, seq_d;
    logic [TDEST_WIDTH-1:0] rr_q, rr_d;
    logic [CNT_WIDTH-1:0]   pkts_q, pkts_d;
    logic [CNT_WIDTH-1:0]   beats_q, beats_d;
    logic                   done_q, done_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q, tlast_d;
    logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
    logic [TID_WIDTH-1:0]   tid_q, tid_d;
    logic [PAYLOAD_W-1:0]   pay_q, pay_d;

    logic                   hs, start, clr;
    logic                   lfsr_step;
    logic [15:0]            lfsr_nxt;
    logic [LEN_WIDTH-1:0]   len_in;
    logic [TDEST_WIDTH-1:0] start_dest;
    dest_mode_t             mode_in;

    noc_lfsr16 u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .step_i     (lfsr_step),
        .load_seed_i(clr),
        .next_o     (lfsr_nxt)
    );

    function automatic logic [TDEST_WIDTH-1:0] rr_next(input logic [TDEST_WIDTH-1:0] p);
        int unsigned n;
        n = (32'(p) + 1) % NUM_ROUTERS;
        if (SKIP_SELF && n == SRC_ID) n = (n + 1) % NUM_ROUTERS;
        return TDEST_WIDTH'(n);
    endfunction

    function automatic logic [TDEST_WIDTH-1:0] lfsr_dest(input logic [15:0] v);
        int unsigned d;
        d = 32'(v) % NUM_ROUTERS;
        if (SKIP_SELF && d == SRC_ID) d = (d + 1) % NUM_ROUTERS;
        return TDEST_WIDTH'(d);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] x);
        return (x == '1) ? x : x + CNT_WIDTH'(1);
    endfunction

    always_comb begin
        mode_in = dest_mode_t'(dest_mode);
        len_in  = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
        case (mode_in)
            RR:      start_dest = rr_q;
            LFSR:    start_dest = lfsr_dest(lfsr_nxt);
            default: start_dest = fixed_dest;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        len_d     = len_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        num_d     = num_q;
        seq_d     = seq_q;
        rr_d      = rr_q;
        pkts_d    = pkts_q;
        beats_d   = beats_q;
        done_d    = done_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tdest_d   = tdest_q;
        tid_d     = tid_q;
        pay_d     = pay_q;
        lfsr_step = 1'b0;
        start     = 1'b0;
        hs        = tvalid_q & axis.tready;
        clr       = clear & ((state_q == IDLE) | (state_q == DONE));

        unique case (state_q)
            IDLE: begin
                if (enable && !clear) start = 1'b1;
            end
            SEND: begin
                if (hs) begin
                    beats_d = sat_inc(beats_q);
                    if (tlast_q) begin
                        pkts_d = sat_inc(pkts_q);
                        seq_d  = seq_q + SEQ_W'(1);
                        if (num_q != '0 && pkts_q + CNT_WIDTH'(1) == num_q) begin
                            state_d  = DONE;
                            done_d   = 1'b1;
                            tvalid_d = 1'b0;
                        end else if (!enable) begin
                            state_d  = IDLE;
                            tvalid_d = 1'b0;
                        end else if (gap_q == '0) begin
                            start = 1'b1;
                        end else begin
                            state_d   = GAP;
                            gap_cnt_d = gap_q;
                            tvalid_d  = 1'b0;
                        end
                    end else begin
                        beat_d  = beat_q + LEN_WIDTH'(1);
                        tlast_d = (beat_d == len_q - LEN_WIDTH'(1));
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == LEN_WIDTH'(1)) begin
                    if (enable) start = 1'b1;
                    else        state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - LEN_WIDTH'(1);
                end
            end
            DONE: begin
                if (!enable) state_d = IDLE;
            end
        endcase

        // New packet: config re-latched from the live inputs every time
        if (start) begin
            state_d   = SEND;
            len_d     = len_in;
            gap_d     = gap_cycles;
            num_d     = num_packets;
            tid_d     = tid_cfg;
            beat_d    = '0;
            tvalid_d  = 1'b1;
            tlast_d   = (len_in == LEN_WIDTH'(1));
            tdest_d   = start_dest;
            if (mode_in == RR) rr_d = rr_next(rr_q);
            lfsr_step = (mode_in == LFSR);
        end

        if (clr) begin
            pkts_d  = '0;
            beats_d = '0;
            seq_d   = '0;
            rr_d    = FIRST_DEST;
            done_d  = 1'b0;
        end

        if (!tvalid_d) begin
            tlast_d = 1'b0;
            tdest_d = '0;
            tid_d   = '0;
            pay_d   = '0;
        end else begin
            pay_d = '0;
            pay_d[BEAT_LSB +: BEAT_W] = BEAT_W'(beat_d);
            pay_d[SEQ_LSB  +: SEQ_W]  = seq_d;
            pay_d[SRC_LSB  +: SRC_W]  = SRC_W'(SRC_ID);
            pay_d[LEN_LSB  +: LEN_W]  = LEN_W'(len_d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            num_q     <= '0;
            seq_q     <= '0;
            rr_q      <= FIRST_DEST;
            pkts_q    <= '0;
            beats_q   <= '0;
            done_q    <= 1'b0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tdest_q   <= '0;
            tid_q     <= '0;
            pay_q     <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            num_q     <= num_d;
            seq_q     <= seq_d;
            rr_q      <= rr_d;
            pkts_q    <= pkts_d;
            beats_q   <= beats_d;
            done_q    <= done_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tdest_q   <= tdest_d;
            tid_q     <= tid_d;
            pay_q     <= pay_d;
        end
    end

    assign axis.tvalid = tvalid_q;
    assign axis.tlast  = tlast_q;
    assign axis.tdest  = tdest_q;
    assign axis.tid    = tid_q;
    assign axis.tdata  = TDATA_WIDTH'(pay_q);
    assign done        = done_q;
    assign pkts_sent   = pkts_q;
    assign beats_sent  = beats_q;
endmodule
